// File: rtl/pool_rd.sv
// 2x2 stride-2 max pooling over one psum bank: reads SRAM rows in pairs,
// quantizes each psum to DATA_WIDTH bits and emits one pooled row per pair.
module pool_rd #(
   parameter int PSUM_WIDTH = 22,
   parameter int LENPSUM    = 16,
   parameter int DATA_WIDTH = 8,
   localparam int AW = $clog2(LENPSUM),
   localparam int RW = AW - 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                CTRLPOOL_Start,
   input  logic [3:0]                          CTRLPOOL_Shift,
   output logic                                POOLPEB_EnRd,
   output logic [AW-1:0]                       POOLPEB_AddrRd,
   input  logic [PSUM_WIDTH*LENPSUM-1:0]       PEBPOOL_Dat,
   output logic                                POOLOUT_Val,
   input  logic                                OUTPOOL_Rdy,
   output logic [DATA_WIDTH*LENPSUM/2-1:0]     POOLOUT_Dat,
   output logic [RW-1:0]                       POOLOUT_Row,
   output logic                                POOLCTRL_Busy,
   output logic                                POOLCTRL_Done,
   output logic [2:0]                          fsm_state
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, OUT, DONE} state_t;

   localparam logic [RW-1:0] KLAST = RW'(LENPSUM/2 - 1);
   localparam logic signed [PSUM_WIDTH-1:0] QMAX = PSUM_WIDTH'((1 << DATA_WIDTH) - 1);

   state_t                           state, state_nxt;
   logic [RW-1:0]                    k;
   logic [3:0]                       shift;
   logic [PSUM_WIDTH*LENPSUM-1:0]    row_buf;
   logic [DATA_WIDTH*LENPSUM/2-1:0]  pooled;

   // Negative psums clamp to 0; the arithmetic shift never wraps at PSUM_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] quant(input logic signed [PSUM_WIDTH-1:0] p,
                                                   input logic [3:0] sh);
      logic signed [PSUM_WIDTH-1:0] s;
      s = p >>> sh;
      if (p[PSUM_WIDTH-1])
         quant = '0;
      else if (s > QMAX)
         quant = '1;
      else
         quant = s[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      max2 = (a > b) ? a : b;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      POOLPEB_EnRd   = 1'b0;
      POOLPEB_AddrRd = '0;
      POOLOUT_Val    = 1'b0;
      POOLCTRL_Busy  = 1'b1;
      POOLCTRL_Done  = 1'b0;
      case (state)
         IDLE: begin
            POOLCTRL_Busy = 1'b0;
            if (CTRLPOOL_Start) state_nxt = RD0;
         end
         RD0: begin
            POOLPEB_EnRd   = 1'b1;
            POOLPEB_AddrRd = {k, 1'b0};
            state_nxt      = RD1;
         end
         RD1: begin
            POOLPEB_EnRd   = 1'b1;
            POOLPEB_AddrRd = {k, 1'b1};
            state_nxt      = CAP;
         end
         CAP: state_nxt = OUT;
         OUT: begin
            POOLOUT_Val = 1'b1;
            if (OUTPOOL_Rdy) state_nxt = (k == KLAST) ? DONE : RD0;
         end
         DONE: begin
            POOLCTRL_Done = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fsm_state = state;

   // Even row comes from the buffer, odd row straight off the read bus.
   always_comb begin
      pooled = '0;
      for (int i = 0; i < LENPSUM/2; i++) begin
         pooled[i*DATA_WIDTH +: DATA_WIDTH] = max2(
            max2(quant(row_buf[(2*i)*PSUM_WIDTH +: PSUM_WIDTH], shift),
                 quant(row_buf[(2*i+1)*PSUM_WIDTH +: PSUM_WIDTH], shift)),
            max2(quant(PEBPOOL_Dat[(2*i)*PSUM_WIDTH +: PSUM_WIDTH], shift),
                 quant(PEBPOOL_Dat[(2*i+1)*PSUM_WIDTH +: PSUM_WIDTH], shift)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k           <= '0;
         shift       <= '0;
         row_buf     <= '0;
         POOLOUT_Dat <= '0;
         POOLOUT_Row <= '0;
      end else begin
         if (state == IDLE && CTRLPOOL_Start) begin
            k     <= '0;
            shift <= CTRLPOOL_Shift;
         end
         if (state == RD1) row_buf <= PEBPOOL_Dat;
         if (state == CAP) begin
            POOLOUT_Dat <= pooled;
            POOLOUT_Row <= k;
         end
         if (state == OUT && OUTPOOL_Rdy && k != KLAST) k <= k + 1'b1;
      end
   end

endmodule

// File: doc/pool_rd.md
POOL_RD -- requirements
Module: pool_rd

Interface
REQ-001 Parameter PSUM_WIDTH, default 22, signed width of one partial sum.
REQ-002 Parameter LENPSUM, default 16, psums per SRAM row and rows per bank (even, power of 2).
REQ-003 Parameter DATA_WIDTH, default 8, unsigned output pixel width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 CTRLPOOL_Start  in  1  one-cycle pulse: finished psum bank ready for pooling.
REQ-007 CTRLPOOL_Shift  in  4  right-shift amount for quantization, sampled on accepted Start.
REQ-008 POOLPEB_EnRd  out  1  SRAM read enable to PEB.
REQ-009 POOLPEB_AddrRd  out  log2(LENPSUM)  SRAM row address to PEB.
REQ-010 PEBPOOL_Dat  in  PSUM_WIDTH*LENPSUM  read data, valid exactly 1 cycle after EnRd; psum j at bits [j*PSUM_WIDTH +: PSUM_WIDTH].
REQ-011 POOLOUT_Val  out  1  output row valid.
REQ-012 OUTPOOL_Rdy  in  1  downstream ready; transfer when Val&Rdy.
REQ-013 POOLOUT_Dat  out  DATA_WIDTH*LENPSUM/2  pooled row; pixel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 POOLOUT_Row  out  log2(LENPSUM)-1  index k of pooled row on POOLOUT_Dat.
REQ-015 POOLCTRL_Busy  out  1  high in every state except IDLE.
REQ-016 POOLCTRL_Done  out  1  one-cycle pulse after last row transferred.

Function
REQ-017 FSM states IDLE, RD0, RD1, CAP, OUT, DONE; reset state IDLE.
REQ-018 IDLE: Start=1 -> RD0, k<=0, shift register <= CTRLPOOL_Shift; Start ignored in all other states.
REQ-019 RD0: EnRd=1, AddrRd=2k; -> RD1.
REQ-020 RD1: EnRd=1, AddrRd=2k+1; register PEBPOOL_Dat (row 2k) into row buffer; -> CAP.
REQ-021 CAP: EnRd=0; compute pooled row from row buffer and current PEBPOOL_Dat (row 2k+1), register into POOLOUT_Dat, POOLOUT_Row<=k; -> OUT.
REQ-022 EnRd=0 and AddrRd=0 in IDLE, CAP, OUT, DONE.
REQ-023 OUT: Val=1; Dat/Row stable while Rdy=0; on Rdy=1: if k=LENPSUM/2-1 -> DONE, else k<=k+1 -> RD0.
REQ-024 DONE: Done=1 for exactly one cycle; -> IDLE; Start in DONE ignored.
REQ-025 Per psum quantize: q = (p<0) ? 0 : p>>>shift; if q > 2^DATA_WIDTH-1 then q = 2^DATA_WIDTH-1.
REQ-026 Pixel i = max of q over psums 2i, 2i+1 of row 2k and of row 2k+1 (2x2 window, stride 2).
REQ-027 Arithmetic done at PSUM_WIDTH bits before saturation; no wrap-around, negative psums always map to 0.
REQ-028 Latency: Start at cycle 0 -> RD0 cycle 1, first Val at cycle 4; min 4 cycles per pooled row with Rdy held 1.
REQ-029 Rdy asserted while Val=0 has no effect.
REQ-030 k counter saturates at LENPSUM/2-1; never wraps within a pass.

Reset
REQ-031 rst=1 at any time forces IDLE immediately: EnRd=0, AddrRd=0, Val=0, Dat=0, Row=0, Busy=0, Done=0, k=0, shift=0, row buffer=0.
REQ-032 Reset mid-pass abandons the pass; after release no output until a new Start.

Verification
REQ-033 Start, Shift=0, all psums=5, Rdy=1 -> EnRd addrs 0,1 at cycles 1,2; Val at cycle 4 Dat all 0x05 Row=0; 8 rows total; Done one pulse after row 7 transfer.
REQ-034 Row 2k psum 2i = -100, others 300, Shift=0 -> pixels saturate to 0xFF; all psums -1 -> pixels 0x00.
REQ-035 Shift=2, window {40, 13, -7, 39} -> pixel 10 (40>>>2); Shift=15, psum 2^21-1 -> 63.
REQ-036 Rdy held 0 for 10 cycles during OUT -> Val stays 1, Dat/Row unchanged, EnRd stays 0; Rdy=1 -> next RD0 following cycle.
REQ-037 Start pulsed while Busy and in DONE -> ignored, exactly 8 rows produced, single Done.
REQ-038 rst asserted during RD1 of row 3 -> all outputs 0 same cycle; after release and new Start, pass restarts at Row=0 addr 0.
